// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the 7-segment capture monitor.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anode codes are active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [5:0] AN_ONES = 6'b111110;
  localparam logic [5:0] AN_TENS = 6'b111101;
  localparam logic [5:0] AN_NONE = 6'b111111;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // tens*10 + ones using shift-add; digits <= 9 keep the result within 7 bits.
  function automatic logic [6:0] bcd_to_value(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Bundle of the sampled display bus and the monitor's result signals.
interface sevenseg_capture_if;
  import sevenseg_pkg::*;

  // No backpressure: value_valid, value_changed and decode_err are single-cycle
  // pulses that the consumer must sample on the cycle they are high.
  logic [5:0] an_in;
  logic [7:0] seg_in;
  logic [6:0] value_out;
  logic       value_valid;
  logic       value_changed;
  logic       decode_err;
  logic       display_lost;
  state_t     state_dbg;

  modport master (
    output an_in, seg_in,
    input  value_out, value_valid, value_changed, decode_err, display_lost, state_dbg
  );

  modport slave (
    input  an_in, seg_in,
    output value_out, value_valid, value_changed, decode_err, display_lost, state_dbg
  );

endinterface

// File: rtl/sevenseg_to_bcd.sv
// Combinational inverse of the display encoder table: segment pattern to BCD digit.
module sevenseg_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_digit
);

  always_comb begin
    o_valid = 1'b1;
    o_digit = 4'd0;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Multiplexed 7-segment bus monitor: filters, decodes and reassembles the
// two-digit displayed value, flagging bad patterns and refresh loss.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  sevenseg_capture_if.slave  bus
);

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  STABLE_SAT  = 8'(STABLE_CYCLES);
  localparam logic [23:0] TO_SAT      = 24'(TIMEOUT_CYCLES);

  logic [5:0]  r_an, r_an_d;
  logic [7:0]  r_seg, r_seg_d;
  logic [7:0]  r_cnt;
  state_t      r_state, w_next;
  logic        w_accept, w_changed;
  logic [3:0]  r_ones, r_tens, w_ones_n, w_tens_n, w_bcd;
  logic        r_ones_vld, r_tens_vld, w_ones_vld_n, w_tens_vld_n;
  logic        w_bcd_valid, w_is_ones, w_is_tens, w_bad_an, w_digit_ok, w_seg_bad, w_complete;
  logic [6:0]  r_value, w_new_value;
  logic        r_vv, r_chg, r_err;
  logic [23:0] r_to;

  assign w_changed = ({r_an, r_seg} != {r_an_d, r_seg_d});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= AN_NONE;
      r_seg   <= 8'hFF;
      r_an_d  <= AN_NONE;
      r_seg_d <= 8'hFF;
      r_cnt   <= 8'd0;
    end else begin
      r_an    <= bus.an_in;
      r_seg   <= bus.seg_in;
      r_an_d  <= r_an;
      r_seg_d <= r_seg;
      if (w_changed)                r_cnt <= 8'd0;
      else if (r_cnt != STABLE_SAT) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SETTLE;
    else     r_state <= w_next;
  end

  // HOLD leaves on a change, or when a change during ACCEPT already restarted the count.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_SETTLE: if (!w_changed && r_cnt == STABLE_LAST) w_next = ST_ACCEPT;
      ST_ACCEPT: begin
        w_accept = 1'b1;
        w_next   = ST_HOLD;
      end
      ST_HOLD:   if (w_changed || r_cnt != STABLE_SAT) w_next = ST_SETTLE;
      default:   w_next = ST_SETTLE;
    endcase
  end

  // The delayed copy holds the pattern that was stable through the filter window.
  sevenseg_to_bcd u_to_bcd (
    .i_seg   (r_seg_d[6:0]),
    .o_valid (w_bcd_valid),
    .o_digit (w_bcd)
  );

  assign w_is_ones    = w_accept && (r_an_d == AN_ONES);
  assign w_is_tens    = w_accept && (r_an_d == AN_TENS);
  assign w_bad_an     = w_accept && !(r_an_d == AN_ONES || r_an_d == AN_TENS || r_an_d == AN_NONE);
  assign w_digit_ok   = (w_is_ones || w_is_tens) && w_bcd_valid;
  assign w_seg_bad    = (w_is_ones || w_is_tens) && !w_bcd_valid;
  assign w_ones_vld_n = r_ones_vld || (w_digit_ok && w_is_ones);
  assign w_tens_vld_n = r_tens_vld || (w_digit_ok && w_is_tens);
  assign w_ones_n     = (w_digit_ok && w_is_ones) ? w_bcd : r_ones;
  assign w_tens_n     = (w_digit_ok && w_is_tens) ? w_bcd : r_tens;
  assign w_complete   = w_digit_ok && w_ones_vld_n && w_tens_vld_n;
  assign w_new_value  = bcd_to_value(w_tens_n, w_ones_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      r_ones_vld <= 1'b0;
      r_tens_vld <= 1'b0;
      r_value    <= 7'd0;
      r_vv       <= 1'b0;
      r_chg      <= 1'b0;
      r_err      <= 1'b0;
      r_to       <= 24'd0;
    end else begin
      r_ones <= w_ones_n;
      r_tens <= w_tens_n;
      r_vv   <= w_complete;
      r_chg  <= w_complete && (w_new_value != r_value);
      r_err  <= w_seg_bad || w_bad_an;
      if (w_seg_bad || w_complete) begin
        r_ones_vld <= 1'b0;
        r_tens_vld <= 1'b0;
      end else begin
        r_ones_vld <= w_ones_vld_n;
        r_tens_vld <= w_tens_vld_n;
      end
      if (w_complete) r_value <= w_new_value;
      if (w_digit_ok)          r_to <= 24'd0;
      else if (r_to != TO_SAT) r_to <= r_to + 24'd1;
    end
  end

  assign bus.value_out     = r_value;
  assign bus.value_valid   = r_vv;
  assign bus.value_changed = r_chg;
  assign bus.decode_err    = r_err;
  assign bus.display_lost  = (r_to == TO_SAT);
  assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized self-checking bench for sevenseg_capture with a slot-level reference model.
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_capture_if bus ();

  sevenseg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Observed pulses
  logic [6:0] obs_q[$];
  logic       obs_chg_q[$];
  int         err_cnt;

  // Expected results from the model
  logic [6:0] exp_q[$];
  logic       exp_chg_q[$];
  int         exp_err;

  // Reference model state
  logic [6:0]  pat [10];
  int          m_ones, m_tens, m_value;
  bit          m_ov, m_tv, m_have_prev;
  logic [13:0] m_prev;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.value_valid) begin
        obs_q.push_back(bus.value_out);
        obs_chg_q.push_back(bus.value_changed);
      end
      if (bus.decode_err) err_cnt++;
    end
  end

  task automatic clear_scoreboard();
    obs_q.delete(); obs_chg_q.delete(); err_cnt = 0;
    exp_q.delete(); exp_chg_q.delete(); exp_err = 0;
  endtask

  task automatic model_reset();
    m_ones = 0; m_tens = 0; m_value = 0;
    m_ov = 0; m_tv = 0; m_have_prev = 0; m_prev = '0;
  endtask

  task automatic model_accept(input logic [5:0] an, input logic [7:0] seg);
    int idx, v;
    idx = -1;
    for (int i = 0; i < 10; i++) if (pat[i] == seg[6:0]) idx = i;
    if (an == 6'b111110 || an == 6'b111101) begin
      if (idx < 0) begin
        exp_err++; m_ov = 0; m_tv = 0;
      end else begin
        if (an == 6'b111110) begin m_ones = idx; m_ov = 1; end
        else                 begin m_tens = idx; m_tv = 1; end
        if (m_ov && m_tv) begin
          v = m_tens * 10 + m_ones;
          exp_q.push_back(7'(v));
          exp_chg_q.push_back(v != m_value);
          m_value = v; m_ov = 0; m_tv = 0;
        end
      end
    end else if (an != 6'b111111) begin
      exp_err++;
    end
  endtask

  // Long holds are accepted once if the pattern differs from what preceded them;
  // holds shorter than the filter window are never accepted.
  task automatic model_slot(input logic [5:0] an, input logic [7:0] seg, input int cycles);
    if (cycles >= STABLE + 4 && (!m_have_prev || {an, seg} != m_prev)) model_accept(an, seg);
    m_prev = {an, seg};
    m_have_prev = 1;
  endtask

  task automatic drive_slot(input logic [5:0] an, input logic [7:0] seg, input int cycles);
    bus.an_in  = an;
    bus.seg_in = seg;
    model_slot(an, seg, cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.an_in = 6'h3F;
    bus.seg_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_scoreboard();
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    tests_run++;
    if (bus.value_out !== 7'd0) begin tests_failed++; $display("FAIL reset_value got %0d want 0", bus.value_out); end
    tests_run++;
    if ({bus.value_valid, bus.value_changed, bus.decode_err, bus.display_lost} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 0000", {bus.value_valid, bus.value_changed, bus.decode_err, bus.display_lost});
    end
    tests_run++;
    if (bus.state_dbg !== ST_SETTLE) begin tests_failed++; $display("FAIL reset_state got %0d want %0d", bus.state_dbg, ST_SETTLE); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_15();
    clear_scoreboard();
    drive_slot(6'b111110, 8'h92, 100);
    drive_slot(6'b111101, 8'hF9, 100);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL frame15_count got %0d want 1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL frame15_value got %0d want %0d", obs_q[0], exp_q[0]); end
      tests_run++;
      if (obs_chg_q[0] !== 1'b1) begin tests_failed++; $display("FAIL frame15_changed got %0b want 1", obs_chg_q[0]); end
    end
    tests_run++;
    if (bus.value_out !== 7'd15) begin tests_failed++; $display("FAIL frame15_out got %0d want 15", bus.value_out); end
  endtask

  task automatic test_repeat();
    clear_scoreboard();
    drive_slot(6'b111110, 8'h12, 100);
    drive_slot(6'b111101, 8'h79, 100);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL repeat_count got %0d want 1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== 7'd15) begin tests_failed++; $display("FAIL repeat_value got %0d want 15", obs_q[0]); end
      tests_run++;
      if (obs_chg_q[0] !== 1'b0) begin tests_failed++; $display("FAIL repeat_changed got %0b want 0", obs_chg_q[0]); end
    end
  endtask

  task automatic test_glitch();
    clear_scoreboard();
    drive_slot(6'b111110, 8'h92, 30);
    drive_slot(6'b111110, 8'h80, 5);
    drive_slot(6'b111110, 8'h92, 30);
    drive_slot(6'b111101, 8'hF9, 40);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL glitch_count got %0d want 1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== 7'd15) begin tests_failed++; $display("FAIL glitch_value got %0d want 15", obs_q[0]); end
    end
    tests_run++;
    if (err_cnt != 0) begin tests_failed++; $display("FAIL glitch_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_bad_seg();
    clear_scoreboard();
    drive_slot(6'b111110, 8'hFF, 40);
    @(negedge clk);
    tests_run++;
    if (err_cnt != 1) begin tests_failed++; $display("FAIL badseg_err got %0d want 1", err_cnt); end
    drive_slot(6'b111101, 8'hB0, 40);
    drive_slot(6'b111110, 8'hF9, 40);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL badseg_count got %0d want 1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== 7'd31) begin tests_failed++; $display("FAIL badseg_value got %0d want 31", obs_q[0]); end
      tests_run++;
      if (obs_chg_q[0] !== 1'b1) begin tests_failed++; $display("FAIL badseg_changed got %0b want 1", obs_chg_q[0]); end
    end
  endtask

  task automatic test_bad_anode();
    clear_scoreboard();
    drive_slot(6'b111100, 8'h92, 40);
    @(negedge clk);
    tests_run++;
    if (err_cnt != 1) begin tests_failed++; $display("FAIL badan_err got %0d want 1", err_cnt); end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL badan_valid got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [5:0] an;
    logic [7:0] seg;
    int kind, len;
    bit legal;
    clear_scoreboard();
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(24, 40);
      seg  = {1'($urandom_range(0, 1)), 7'h00};
      if (kind <= 5) begin
        an = (kind <= 2) ? 6'b111110 : 6'b111101;
        seg[6:0] = pat[$urandom_range(0, 9)];
      end else if (kind == 6) begin
        an = 6'b111111;
        seg = 8'($urandom);
      end else if (kind == 7) begin
        do an = 6'($urandom); while (an == 6'b111110 || an == 6'b111101 || an == 6'b111111);
        seg[6:0] = pat[$urandom_range(0, 9)];
      end else if (kind == 8) begin
        an = $urandom_range(0, 1) ? 6'b111110 : 6'b111101;
        do begin
          seg[6:0] = 7'($urandom);
          legal = 0;
          for (int i = 0; i < 10; i++) if (pat[i] == seg[6:0]) legal = 1;
        end while (legal);
      end else begin
        an = $urandom_range(0, 1) ? 6'b111110 : 6'b111101;
        seg[6:0] = 7'($urandom);
        len = $urandom_range(1, 10);
      end
      drive_slot(an, seg, len);
    end
    drive_slot(6'b111111, 8'hFF, 30);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if ({obs_q[i], obs_chg_q[i]} !== {exp_q[i], exp_chg_q[i]}) begin
          tests_failed++;
          $display("FAIL random_frame%0d got %0d/chg%0b want %0d/chg%0b", i, obs_q[i], obs_chg_q[i], exp_q[i], exp_chg_q[i]);
        end
      end
    end
    tests_run++;
    if (err_cnt != exp_err) begin tests_failed++; $display("FAIL random_err got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_timeout();
    bit cleared;
    reset_dut();
    drive_slot(6'b111111, 8'hFF, 40);
    @(negedge clk);
    tests_run++;
    if (bus.display_lost !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got %0b want 0", bus.display_lost); end
    drive_slot(6'b111111, 8'hFF, 60);
    @(negedge clk);
    tests_run++;
    if (bus.display_lost !== 1'b1) begin tests_failed++; $display("FAIL timeout_lost got %0b want 1", bus.display_lost); end
    @(posedge clk); #1;
    bus.an_in = 6'b111110;
    bus.seg_in = 8'hC0;
    model_slot(6'b111110, 8'hC0, 40);
    cleared = 0;
    for (int i = 0; i < 40 && !cleared; i++) begin
      @(negedge clk);
      if (bus.display_lost === 1'b0) cleared = 1;
    end
    tests_run++;
    if (!cleared) begin tests_failed++; $display("FAIL timeout_recover got %0b want 0", bus.display_lost); end
    repeat (30) @(negedge clk);
    tests_run++;
    if (bus.display_lost !== 1'b0) begin tests_failed++; $display("FAIL timeout_stay got %0b want 0", bus.display_lost); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive_slot(6'b111101, 8'h99, 30);
    drive_slot(6'b111110, 8'hA4, 30);
    drive_slot(6'b111110, 8'hF9, 30);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.value_out, bus.value_valid, bus.value_changed, bus.decode_err, bus.display_lost} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got %0d/%b want 0/0000", bus.value_out,
               {bus.value_valid, bus.value_changed, bus.decode_err, bus.display_lost});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    clear_scoreboard();
    drive_slot(6'b111101, 8'hF8, 30);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL midrst_partial got %0d want 0", obs_q.size()); end
    drive_slot(6'b111110, 8'hB0, 30);
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
    else begin
      tests_run++;
      if ({obs_q[0], obs_chg_q[0]} !== {exp_q[0], exp_chg_q[0]}) begin
        tests_failed++;
        $display("FAIL midrst_value got %0d/chg%0b want %0d/chg%0b", obs_q[0], obs_chg_q[0], exp_q[0], exp_chg_q[0]);
      end
    end
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
    bus.an_in = 6'h3F;
    bus.seg_in = 8'hFF;
    model_reset();
    clear_scoreboard();
    test_reset();
    test_frame_15();
    test_repeat();
    test_glitch();
    test_bad_seg();
    test_bad_anode();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side monitor for the multiplexed 7-segment bus driven by the display controller. Samples the active-low anode and segment lines, filters switching glitches, decodes each digit's segment pattern back to BCD, and reassembles the two-digit value. Used on-chip for display self-check and in benches as the scoreboard front end. Flags illegal patterns and loss of refresh activity.

## Interface
- STABLE_CYCLES, 16: consecutive identical samples of {an_in, seg_in} required before a digit is accepted; legal range 2..255.
- TIMEOUT_CYCLES, 1_048_576: cycles without any accepted digit before display_lost asserts; legal range 2..2^24-1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- an_in  in  6  anode selects, active-low, bit0 = ones digit, bit1 = tens digit, bits5:2 unused (must read 1).
- seg_in  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}; dp ignored.
- value_out  out  7  last assembled value tens*10+ones, 0..99.
- value_valid  out  1  one-cycle pulse when value_out updates.
- value_changed  out  1  one-cycle pulse, coincident with value_valid, when the new value differs from the previous one.
- decode_err  out  1  one-cycle pulse on an illegal pattern or illegal anode code.
- display_lost  out  1  level; high while no digit has been accepted for TIMEOUT_CYCLES.

## Operation
- Inputs registered once on entry; all logic works on the registered copy.
- Stability filter: 8-bit counter, cleared whenever registered {an,seg} differs from the previous cycle's value; saturates at STABLE_CYCLES.
- FSM states:
  - SETTLE: counting. At count == STABLE_CYCLES-1 with unchanged input → ACCEPT.
  - ACCEPT (one cycle): classify anode. 6'b111110 → ones slot; 6'b111101 → tens slot; 6'b111111 → blank, no action; any other code → decode_err. Go to HOLD.
  - HOLD: wait for any input change → SETTLE. Ensures one acceptance per refresh slot.
- Segment decode (bits 6:0, active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10. Any other pattern in a ones/tens slot → decode_err, digit discarded, both frame flags cleared.
- Frame assembly: ones_vld/tens_vld flags with digit registers. Accepting a slot overwrites that digit and sets its flag. When both flags set: compute value, pulse value_valid, clear both flags. Order of ones/tens is free.
- value_changed: compare computed value with current value_out before update. First frame after reset counts as changed only if value ≠ 0.
- Timeout counter: cleared on every accepted ones/tens digit, saturates at TIMEOUT_CYCLES; display_lost = (counter == TIMEOUT_CYCLES). Blank slots do not clear it.
- Arithmetic: tens*10 via shift-add ((t<<3)+(t<<1)), 7-bit result, no overflow for digits ≤ 9.

## Timing
- Reset values: value_out 0, all pulses 0, display_lost 0, FSM SETTLE, counters 0, frame flags 0.
- Latency: input change at pins → acceptance after 1 (input reg) + STABLE_CYCLES cycles; value_valid one cycle after ACCEPT of the completing digit.
- Same-cycle decode error and completion impossible (one digit per ACCEPT); error always wins for its own digit.
- Input change during ACCEPT: ignored for that acceptance; FSM proceeds to HOLD, then SETTLE next cycle.
- Reset mid-frame: partial digits discarded, timeout restarts from 0.
- Glitch shorter than STABLE_CYCLES never produces an acceptance.

## Structure
- Package sevenseg_pkg: active-low segment constants SEG_0..SEG_9, SEG_BLANK, anode codes AN_ONES, AN_TENS, AN_NONE, FSM state enum.
- Sub-module sevenseg_to_bcd: combinational pattern → {valid, digit[3:0]}, inverse of the display encoder's table.

## Test plan
- Drive ones=0x12, tens=0x79 each held 100 cycles → value_valid once, value_out=15, value_changed=1.
- Repeat same 15 frame → value_valid=1, value_changed=0.
- 5-cycle glitch of seg=0x00 inside a ones slot, STABLE_CYCLES=16 → no extra acceptance, value unchanged.
- ones slot with seg=0x7F (blank pattern) → decode_err pulse, next valid frame tens=3 ones=1 → value_out=31.
- an_in=6'b111100 held stable → decode_err pulse, no value_valid.
- Hold an_in=6'b111111 for TIMEOUT_CYCLES (small param, 64) → display_lost high; next accepted digit → display_lost low following cycle; assert rst mid-frame → all outputs 0.
